// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot loader.
package mips_boot_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned HDR_W          = 16;
   localparam int unsigned WORD_W         = 32;

   typedef enum logic [2:0] {
      HDR_HI,
      HDR_LO,
      LOAD,
      CHECK,
      RUN,
      ERROR
   } boot_state_t;

   // Byte address of word idx in an image based at base.
   function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                   input logic [HDR_W-1:0]  idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Shifts image bytes into a big-endian word and flags the byte that completes it.
module boot_word_assembler
   import mips_boot_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              shift_en,
   input  logic [7:0]        byte_in,
   output logic [WORD_W-1:0] word_c,
   output logic              word_complete_c
);

   localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

   logic [CNT_W-1:0] byte_cnt;
   logic [23:0]      shreg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt <= '0;
         shreg    <= '0;
      end else if (clr) begin
         byte_cnt <= '0;
      end else if (shift_en) begin
         byte_cnt <= byte_cnt + 1'b1;
         shreg    <= {shreg[15:0], byte_in};
      end
   end

   // The fourth byte is presented combinationally so the word is ready on its accept edge.
   assign word_c          = {shreg, byte_in};
   assign word_complete_c = shift_en && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mips_boot_loader.sv
// Loads a length-prefixed byte image into core memory, then releases the core from reset.
// Optional trailer checksum enabled by defining BOOT_CHECKSUM_EN.
module mips_boot_loader
   import mips_boot_pkg::*;
#(
   parameter int unsigned       MEM_WORDS = 256,
   parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              error,
   output logic [HDR_W-1:0]  words_loaded
);

   boot_state_t       state, next_state, after_load;
   logic              accept, reload_hit, load_wr;
   logic [7:0]        hdr_hi;
   logic [HDR_W-1:0]  n_words, hdr_n;
   logic [WORD_W-1:0] word_c;
   logic              word_complete;
   logic              rx_ready_d, core_rst_d, done_d, error_d;

   assign accept     = rx_valid && rx_ready;
   assign hdr_n      = {hdr_hi, rx_data};
   assign reload_hit = reload && (state == RUN || state == ERROR);

`ifdef BOOT_CHECKSUM_EN
   assign after_load = CHECK;

   logic [7:0] csum;

   // Running XOR over header and payload bytes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         csum <= '0;
      end else if (reload_hit) begin
         csum <= '0;
      end else if (accept && (state == HDR_HI || state == HDR_LO || state == LOAD)) begin
         csum <= csum ^ rx_data;
      end
   end
`else
   assign after_load = RUN;
`endif

   boot_word_assembler u_asm (
      .clk             (clk),
      .rst             (rst),
      .clr             (state != LOAD),
      .shift_en        (accept && state == LOAD),
      .byte_in         (rx_data),
      .word_c          (word_c),
      .word_complete_c (word_complete)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hdr_hi  <= '0;
         n_words <= '0;
      end else if (accept && state == HDR_HI) begin
         hdr_hi  <= rx_data;
      end else if (accept && state == HDR_LO) begin
         n_words <= hdr_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= HDR_HI;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         HDR_HI: if (accept) next_state = HDR_LO;
         HDR_LO: begin
            if (accept) begin
               if (32'(hdr_n) > MEM_WORDS) next_state = ERROR;
               else if (hdr_n == '0)       next_state = after_load;
               else                        next_state = LOAD;
            end
         end
         // Leave only once the final word's write strobe is on the bus.
         LOAD:   if (mem_we && words_loaded == n_words) next_state = after_load;
`ifdef BOOT_CHECKSUM_EN
         CHECK:  if (accept) next_state = (rx_data == csum) ? RUN : ERROR;
`endif
         RUN:    if (reload_hit) next_state = HDR_HI;
         ERROR:  if (reload_hit) next_state = HDR_HI;
         default: next_state = HDR_HI;
      endcase
   end

   always_comb begin
      load_wr    = 1'b0;
      rx_ready_d = 1'b0;
      core_rst_d = 1'b1;
      done_d     = 1'b0;
      error_d    = 1'b0;
      load_wr    = (state == LOAD) && word_complete;
      rx_ready_d = !load_wr && (next_state inside {HDR_HI, HDR_LO, LOAD, CHECK});
      done_d     = (next_state == RUN);
      core_rst_d = !done_d;
      error_d    = (next_state == ERROR);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_ready     <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= BASE_ADDR;
         mem_wdata    <= '0;
         core_rst     <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
      end else begin
         rx_ready <= rx_ready_d;
         mem_we   <= load_wr;
         core_rst <= core_rst_d;
         done     <= done_d;
         error    <= error_d;
         if (load_wr) begin
            mem_addr  <= word_addr(BASE_ADDR, words_loaded);
            mem_wdata <= word_c;
         end
         if (reload_hit)   words_loaded <= '0;
         else if (load_wr) words_loaded <= words_loaded + 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: table vectors, hand sequences and random images.
module tb_mips_boot_loader;

   localparam int unsigned MEM_WORDS = 256;
   localparam logic [31:0] BASE      = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        reload = 1'b0;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        core_rst;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   always #5 clk = ~clk;

   mips_boot_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .reload       (reload),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .core_rst     (core_rst),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Write capture and write-cycle checks
   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   int          cyc = 0;
   int          last_we_cyc = -1;
   int          run_cyc = -1;
   logic        prev_core_rst = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we) begin
         got_addr.push_back(mem_addr);
         got_data.push_back(mem_wdata);
         last_we_cyc = cyc;
         chk("rx_ready_during_write", {31'd0, rx_ready}, 32'd0);
         chk("words_loaded_at_write", {16'd0, words_loaded}, 32'(got_addr.size()));
      end
      if (prev_core_rst && !core_rst) run_cyc = cyc;
      prev_core_rst = core_rst;
   end

   // Reference model: expected writes and end state from the image bytes
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];

   task automatic model(input logic [7:0] s[$], output logic e_done, output logic e_err,
                        output int e_words);
      int n;
      exp_addr.delete();
      exp_data.delete();
      n = int'({s[0], s[1]});
      if (n > MEM_WORDS) begin
         e_done = 1'b0; e_err = 1'b1; e_words = 0;
         return;
      end
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(BASE + 32'(4 * i));
         exp_data.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
      end
      e_words = n; e_done = 1'b1; e_err = 1'b0;
`ifdef BOOT_CHECKSUM_EN
      begin
         logic [7:0] x;
         x = 8'h00;
         for (int i = 0; i < 2 + 4 * n; i++) x = x ^ s[i];
         if (s[2+4*n] != x) begin
            e_done = 1'b0; e_err = 1'b1;
         end
      end
`endif
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      repeat (gap) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      w = 0;
      while (!rx_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
      @(posedge clk);
   endtask

   task automatic send_stream(input logic [7:0] s[$], input int gap, input int reload_at);
      foreach (s[i]) begin
         if (i == reload_at) begin
            @(negedge clk);
            rx_valid = 1'b0;
            reload   = 1'b1;
            @(negedge clk);
            reload   = 1'b0;
         end
         send_byte(s[i], gap);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic run_image(input string tag, input logic [7:0] s[$], input int gap,
                            input int reload_at);
      logic e_done, e_err;
      int   e_words, w, nw;
      model(s, e_done, e_err, e_words);
      got_addr.delete();
      got_data.delete();
      last_we_cyc = -1;
      run_cyc     = -1;
      send_stream(s, gap, reload_at);
      w = 0;
      while (!done && !error && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk({tag, " finished"}, {31'd0, done | error}, 32'd1);
      @(negedge clk);
      chk({tag, " done"}, {31'd0, done}, {31'd0, e_done});
      chk({tag, " error"}, {31'd0, error}, {31'd0, e_err});
      chk({tag, " core_rst"}, {31'd0, core_rst}, {31'd0, !e_done});
      chk({tag, " words_loaded"}, {16'd0, words_loaded}, 32'(e_words));
      chk({tag, " write_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
      nw = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < nw; i++) begin
         chk($sformatf("%s addr[%0d]", tag, i), got_addr[i], exp_addr[i]);
         chk($sformatf("%s data[%0d]", tag, i), got_data[i], exp_data[i]);
      end
`ifndef BOOT_CHECKSUM_EN
      if (e_words > 0) chk({tag, " run_latency"}, 32'(run_cyc - last_we_cyc), 32'd1);
`endif
   endtask

   task automatic do_reload();
      @(negedge clk);
      rx_valid = 1'b0;
      reload   = 1'b1;
      @(negedge clk);
      reload   = 1'b0;
      chk("reload error", {31'd0, error}, 32'd0);
      chk("reload done", {31'd0, done}, 32'd0);
      chk("reload core_rst", {31'd0, core_rst}, 32'd1);
      chk("reload words_loaded", {16'd0, words_loaded}, 32'd0);
      chk("reload rx_ready", {31'd0, rx_ready}, 32'd1);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, " rx_ready"}, {31'd0, rx_ready}, 32'd0);
      chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, " mem_addr"}, mem_addr, BASE);
      chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, " core_rst"}, {31'd0, core_rst}, 32'd1);
      chk({tag, " done"}, {31'd0, done}, 32'd0);
      chk({tag, " error"}, {31'd0, error}, 32'd0);
      chk({tag, " words_loaded"}, {16'd0, words_loaded}, 32'd0);
   endtask

   typedef struct packed {
      logic [95:0] stream;
      logic [3:0]  len;
      logic [1:0]  gap;
      logic        exp_done;
      logic        exp_error;
      logic [15:0] exp_words;
      logic [31:0] exp_last;
   } vec_t;

   function automatic vec_t mk(input logic [95:0] st, input int ln, input int gp, input logic d,
                               input logic e, input int w, input logic [31:0] last);
      vec_t r;
      r.stream = st; r.len = 4'(ln); r.gap = 2'(gp);
      r.exp_done = d; r.exp_error = e; r.exp_words = 16'(w); r.exp_last = last;
      return r;
   endfunction

   vec_t       vecs[$];
   vec_t       cur;
   logic [7:0] s[$];
   logic [7:0] x;
   int         n;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
`ifdef BOOT_CHECKSUM_EN
      vecs.push_back(mk(96'h00022008_00058C09_0004AE00, 11, 0, 1'b1, 1'b0, 2, 32'h8C090004));
      vecs.push_back(mk(96'h00022008_00058C09_0004AE00, 11, 1, 1'b1, 1'b0, 2, 32'h8C090004));
      vecs.push_back(mk(96'h01010000_00000000_00000000,  2, 0, 1'b0, 1'b1, 0, 32'h0));
      vecs.push_back(mk(96'h00000000_00000000_00000000,  3, 0, 1'b1, 1'b0, 0, 32'h0));
      vecs.push_back(mk(96'h00011234_56780900_00000000,  7, 2, 1'b1, 1'b0, 1, 32'h12345678));
      vecs.push_back(mk(96'h00011234_56780800_00000000,  7, 0, 1'b0, 1'b1, 1, 32'h12345678));
`else
      vecs.push_back(mk(96'h00022008_00058C09_00040000, 10, 0, 1'b1, 1'b0, 2, 32'h8C090004));
      vecs.push_back(mk(96'h00022008_00058C09_00040000, 10, 1, 1'b1, 1'b0, 2, 32'h8C090004));
      vecs.push_back(mk(96'h01010000_00000000_00000000,  2, 0, 1'b0, 1'b1, 0, 32'h0));
      vecs.push_back(mk(96'h00000000_00000000_00000000,  2, 0, 1'b1, 1'b0, 0, 32'h0));
      vecs.push_back(mk(96'h00011234_56780000_00000000,  6, 2, 1'b1, 1'b0, 1, 32'h12345678));
`endif

      repeat (3) @(negedge clk);
      chk_reset_values("reset");
      rst = 1'b1;

      for (int v = 0; v < vecs.size(); v++) begin
         cur = vecs[v];
         s.delete();
         for (int i = 0; i < int'(cur.len); i++) s.push_back(cur.stream[95-8*i -: 8]);
         run_image($sformatf("vec%0d", v), s, int'(cur.gap), -1);
         chk($sformatf("vec%0d tbl_done", v), {31'd0, done}, {31'd0, cur.exp_done});
         chk($sformatf("vec%0d tbl_error", v), {31'd0, error}, {31'd0, cur.exp_error});
         chk($sformatf("vec%0d tbl_words", v), {16'd0, words_loaded}, {16'd0, cur.exp_words});
         if (cur.exp_words != 0 && got_data.size() != 0)
            chk($sformatf("vec%0d tbl_last", v), got_data[got_data.size()-1], cur.exp_last);
         do_reload();
      end

      // Asynchronous reset in the middle of a load, then a clean reload from BASE
      got_addr.delete();
      got_data.delete();
      s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09};
      foreach (s[i]) send_byte(s[i], 0);
      #2;
      chk("midload words_loaded", {16'd0, words_loaded}, 32'd1);
      rst = 1'b0;
      #1;
      chk_reset_values("midload_rst");
      rx_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
`ifdef BOOT_CHECKSUM_EN
      s.push_back(8'hAE);
`endif
      run_image("post_rst", s, 0, -1);
      do_reload();

      // Reload pulses outside RUN/ERROR must be ignored
      run_image("reload_ignored", s, 0, 5);
      do_reload();

      for (int t = 0; t < 25; t++) begin
         s.delete();
         n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MEM_WORDS + 1, 65535))
                                         : int'($urandom_range(0, 5));
         s.push_back(8'(n >> 8));
         s.push_back(8'(n));
         if (n <= MEM_WORDS) begin
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
`ifdef BOOT_CHECKSUM_EN
            x = 8'h00;
            foreach (s[i]) x = x ^ s[i];
            if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
            s.push_back(x);
`endif
         end
         run_image($sformatf("rand%0d", t), s, int'($urandom_range(0, 2)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, s.size() - 1)) : -1);
         do_reload();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_boot_loader.md
Name: mips_boot_loader

Overview:
- Upstream companion of the multi-cycle MIPS core.
- Receives a program image as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into the unified instruction/data memory through its write port.
- Holds the core in reset until the image is fully loaded, then releases it so the core fetches from BASE_ADDR.

Parameters:
- MEM_WORDS, 256, memory capacity in 32-bit words; a header count above this is an error.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be word-aligned.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming image byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- reload  in  1  single-cycle pulse in RUN or ERROR restarts loading.
- mem_we  out  1  memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the write.
- mem_wdata  out  32  assembled word.
- core_rst  out  1  active-high reset to the MIPS core.
- done  out  1  image loaded, core running.
- error  out  1  load failed; core held in reset.
- words_loaded  out  16  count of words written so far.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=HDR_HI, rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - core_rst=1, done=0, error=0, words_loaded=0, byte counter=0.
- rx_ready is registered: 1 in HDR_HI, HDR_LO, LOAD and CHECK; 0 in every other state. It also drops to 0 in the cycle mem_we is high, so no byte is accepted during a write.
- A byte is accepted only when rx_valid && rx_ready. Idle cycles with rx_valid=0 are legal anywhere in the stream.
- State machine:
  - HDR_HI: accepted byte becomes N[15:8]; go to HDR_LO.
  - HDR_LO: accepted byte becomes N[7:0].
    - If N > MEM_WORDS, go to ERROR.
    - If N == 0, go to CHECK (feature on) or RUN (feature off).
    - Otherwise go to LOAD.
  - LOAD: bytes shift into the word big-endian; the first byte lands in bits [31:24].
    - On the 4th byte, mem_wdata and mem_addr = BASE_ADDR + 4*words_loaded are registered, and mem_we=1 in the following cycle.
    - words_loaded increments in the same cycle mem_we is high.
    - After the write of word N, go to CHECK (feature on) or RUN (feature off).
  - RUN: core_rst=0 and done=1 from the first RUN cycle. Further rx bytes are ignored (rx_ready=0).
  - ERROR: error=1, core_rst=1, rx_ready=0.
  - reload=1 in RUN or ERROR: next cycle state=HDR_HI, core_rst=1, done=0, error=0, words_loaded=0. reload is ignored in all other states.
- Write latency: mem_we is asserted exactly 1 cycle after the 4th byte is accepted.
- Address arithmetic: 32-bit, increments by 4 per word, no wrap (N ≤ MEM_WORDS guarantees this).
- Reset asserted mid-load aborts immediately. Memory contents already written are left as-is; the next load overwrites them.

Optional Feature:
- BOOT_CHECKSUM_EN defined:
  - After the payload, state CHECK accepts one trailer byte.
  - Expected value = XOR of all header and payload bytes.
  - Match: go to RUN. Mismatch: go to ERROR.
  - For N=0 the trailer covers the header bytes only.
- BOOT_CHECKSUM_EN undefined:
  - CHECK state and XOR register are absent.
  - After the last word write (or immediately after the header for N=0), go directly to RUN.

Decomposition:
- Package mips_boot_pkg:
  - State enum boot_state_t {HDR_HI, HDR_LO, LOAD, CHECK, RUN, ERROR}.
  - BYTES_PER_WORD=4.
  - Header width constant HDR_W=16.
- One sub-module, boot_word_assembler: a byte shift register plus 2-bit byte counter that flags word_complete. The FSM, address counter and checksum stay in the top module.

Test Plan:
- Header 0x0002, payload 20 08 00 05 / 8C 09 00 04, rx_valid held high:
  - Write 1: mem_we with addr 0x0, wdata 0x20080005.
  - Write 2: addr 0x4, wdata 0x8C090004.
  - core_rst falls 1 cycle after the second write; done=1; words_loaded=2.
- Same stream with rx_valid toggling every other cycle: identical writes and values; no byte accepted while mem_we=1.
- Header 0x0101 with MEM_WORDS=256: error=1 after the 2nd byte, core_rst stays 1, zero writes. A reload pulse then returns to HDR_HI with error=0.
- Header 0x0000: core_rst=0 with zero writes, immediately (feature off) or after trailer 0x00 (feature on).
- rst pulled low after 6 payload bytes: all outputs return to reset values asynchronously. A full reload then produces correct writes starting at BASE_ADDR.
- BOOT_CHECKSUM_EN, 1-word image 00 01 12 34 56 78:
  - Trailer 0x09: RUN, done=1.
  - Trailer 0x08: ERROR, core_rst=1.
